// File: rtl/tk_pkg.sv
// Shared time-field widths, limits and CTO bit offsets for the timekeeper,
// alarm and display blocks.
package tk_pkg;

  localparam int unsigned MIN_ONES_W = 4;
  localparam int unsigned MIN_TENS_W = 3;
  localparam int unsigned HOUR_W     = 5;

  localparam int unsigned MIN_ONES_MOD = 10;
  localparam int unsigned MIN_TENS_MOD = 6;
  localparam int unsigned HOUR_MOD     = 24;
  localparam int unsigned MIN_MAX      = 59;

  localparam logic [MIN_ONES_W-1:0] MIN_ONES_MAX = 4'd9;
  localparam logic [MIN_TENS_W-1:0] MIN_TENS_MAX = 3'd5;
  localparam logic [HOUR_W-1:0]     HOUR_MAX     = 5'd23;

  localparam int unsigned MIN_ONES_LSB = 0;
  localparam int unsigned MIN_TENS_LSB = 4;
  localparam int unsigned HOUR_LSB     = 7;
  localparam int unsigned DAY_LSB      = 12;

endpackage

// File: rtl/tk_mod_counter.sv
// Modulo-MOD field counter with synchronous clear and load; Carry flags the
// increment that wraps the field back to zero.
module tk_mod_counter #(
  parameter int unsigned MOD = 10,
  parameter int unsigned W   = 4
) (
  input  logic         Clk,
  input  logic         Clr,
  input  logic         Ld,
  input  logic [W-1:0] D,
  input  logic         Inc,
  output logic [W-1:0] Q,
  output logic         Carry
);

  localparam logic [W-1:0] TOP = W'(MOD - 1);

  assign Carry = Inc & (Q == TOP);

  always_ff @(posedge Clk) begin
    if (Clr)      Q <= '0;
    else if (Ld)  Q <= D;
    else if (Inc) Q <= (Q == TOP) ? '0 : Q + W'(1);
  end

endmodule

// File: rtl/timekeeper_param.sv
// Day/hour/minute timekeeper with prescaler, validated load and rollover pulses.
// Define TK_SECONDS_EN to add a BCD seconds field (Sec) ahead of the minutes.
module timekeeper_param
  import tk_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 60,
  parameter int unsigned DAY_COUNT = 7,
  parameter int unsigned DAY_W     = 3
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              En,
  input  logic              Ld,
  input  logic [12+DAY_W-1:0] CTI,
  output logic [12+DAY_W-1:0] CTO,
  output logic              Ld_err,
  output logic              Min_tick,
  output logic              Hr_tick,
  output logic              Day_tick
`ifdef TK_SECONDS_EN
  ,
  output logic [6:0]        Sec
`endif
);

  localparam int unsigned       PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]     PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [DAY_W:0]    DAY_LIM = (DAY_W + 1)'(DAY_COUNT);

  logic [PW-1:0]         presc;
  logic                  cti_valid, ld_ok, base_tick;
  logic                  min_inc, ones_carry, tens_carry, hour_carry, day_carry_unused;
  logic [MIN_ONES_W-1:0] ones_q;
  logic [MIN_TENS_W-1:0] tens_q;
  logic [HOUR_W-1:0]     hour_q;
  logic [DAY_W-1:0]      day_q;

  assign cti_valid = (CTI[MIN_ONES_LSB +: MIN_ONES_W] <= MIN_ONES_MAX) &&
                     (CTI[MIN_TENS_LSB +: MIN_TENS_W] <= MIN_TENS_MAX) &&
                     (CTI[HOUR_LSB +: HOUR_W]         <= HOUR_MAX) &&
                     ({1'b0, CTI[DAY_LSB +: DAY_W]}   <  DAY_LIM);
  assign ld_ok     = Ld & cti_valid;
  // Any load, accepted or rejected, blocks counting that cycle.
  assign base_tick = En & (presc == PRE_MAX) & ~Ld & ~Clr;

  always_ff @(posedge Clk) begin
    if (Clr)                     presc <= '0;
    else if (Ld) begin
      if (cti_valid)             presc <= '0;
    end
    else if (En)                 presc <= (presc == PRE_MAX) ? '0 : presc + PW'(1);
  end

`ifdef TK_SECONDS_EN
  logic [3:0] sec_ones_q;
  logic [2:0] sec_tens_q;
  logic       sec_ones_carry;

  tk_mod_counter #(.MOD(10), .W(4)) u_sec_ones (
    .Clk(Clk), .Clr(Clr), .Ld(ld_ok), .D(4'd0), .Inc(base_tick),
    .Q(sec_ones_q), .Carry(sec_ones_carry)
  );
  tk_mod_counter #(.MOD(6), .W(3)) u_sec_tens (
    .Clk(Clk), .Clr(Clr), .Ld(ld_ok), .D(3'd0), .Inc(sec_ones_carry),
    .Q(sec_tens_q), .Carry(min_inc)
  );
  assign Sec = {sec_tens_q, sec_ones_q};
`else
  assign min_inc = base_tick;
`endif

  tk_mod_counter #(.MOD(MIN_ONES_MOD), .W(MIN_ONES_W)) u_min_ones (
    .Clk(Clk), .Clr(Clr), .Ld(ld_ok), .D(CTI[MIN_ONES_LSB +: MIN_ONES_W]),
    .Inc(min_inc), .Q(ones_q), .Carry(ones_carry)
  );
  tk_mod_counter #(.MOD(MIN_TENS_MOD), .W(MIN_TENS_W)) u_min_tens (
    .Clk(Clk), .Clr(Clr), .Ld(ld_ok), .D(CTI[MIN_TENS_LSB +: MIN_TENS_W]),
    .Inc(ones_carry), .Q(tens_q), .Carry(tens_carry)
  );
  tk_mod_counter #(.MOD(HOUR_MOD), .W(HOUR_W)) u_hour (
    .Clk(Clk), .Clr(Clr), .Ld(ld_ok), .D(CTI[HOUR_LSB +: HOUR_W]),
    .Inc(tens_carry), .Q(hour_q), .Carry(hour_carry)
  );
  tk_mod_counter #(.MOD(DAY_COUNT), .W(DAY_W)) u_day (
    .Clk(Clk), .Clr(Clr), .Ld(ld_ok), .D(CTI[DAY_LSB +: DAY_W]),
    .Inc(hour_carry), .Q(day_q), .Carry(day_carry_unused)
  );

  assign CTO = {day_q, hour_q, tens_q, ones_q};

  // Pulses are registered from the same carries that update the fields, so
  // they line up with the cycle CTO first shows the new value.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      Ld_err   <= 1'b0;
      Min_tick <= 1'b0;
      Hr_tick  <= 1'b0;
      Day_tick <= 1'b0;
    end else begin
      Ld_err   <= Ld & ~cti_valid;
      Min_tick <= min_inc;
      Hr_tick  <= tens_carry;
      Day_tick <= hour_carry;
    end
  end

endmodule

// File: tb/tb_timekeeper_param.sv
// Directed self-checking bench for timekeeper_param (TICK_DIV=4, 7-day cycle).
module tb_timekeeper_param;

  logic        clk = 1'b0;
  logic        clr, en, ld;
  logic [14:0] cti, cto;
  logic        ld_err, min_tick, hr_tick, day_tick;
`ifdef TK_SECONDS_EN
  logic [6:0]  sec;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  timekeeper_param #(.TICK_DIV(4), .DAY_COUNT(7), .DAY_W(3)) dut (
    .Clk(clk), .Clr(clr), .En(en), .Ld(ld), .CTI(cti), .CTO(cto),
    .Ld_err(ld_err), .Min_tick(min_tick), .Hr_tick(hr_tick), .Day_tick(day_tick)
`ifdef TK_SECONDS_EN
    , .Sec(sec)
`endif
  );

  function automatic logic [14:0] mk(input int d, input int h, input int t, input int o);
    return {3'(d), 5'(h), 3'(t), 4'(o)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_all(input string tag, input logic [14:0] e_cto,
                           input logic e_mt, input logic e_ht, input logic e_dt,
                           input logic e_le);
    check({tag, ".cto"}, 32'(cto), 32'(e_cto));
    check({tag, ".min_tick"}, 32'(min_tick), 32'(e_mt));
    check({tag, ".hr_tick"},  32'(hr_tick),  32'(e_ht));
    check({tag, ".day_tick"}, 32'(day_tick), 32'(e_dt));
    check({tag, ".ld_err"},   32'(ld_err),   32'(e_le));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; ld = 1'b0; cti = '0;
    step();
    check_all("reset", mk(0,0,0,0), 0, 0, 0, 0);

    // First tick TICK_DIV enabled cycles after reset.
    clr = 1'b0; en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_all("pre_first_tick", mk(0,0,0,0), 0, 0, 0, 0);
    end
    step();
    check_all("first_tick", mk(0,0,0,1), 1, 0, 0, 0);
    step();
    check_all("after_first_tick", mk(0,0,0,1), 0, 0, 0, 0);

    // Load 23:59 day 6, then wrap everything.
    ld = 1'b1; cti = mk(6,23,5,9);
    step();
    check_all("load_2359", mk(6,23,5,9), 0, 0, 0, 0);
    ld = 1'b0;
    for (int i = 1; i <= 3; i++) step();
    check("hold_2359", 32'(cto), 32'(mk(6,23,5,9)));
    step();
    check_all("week_wrap", mk(0,0,0,0), 1, 1, 1, 0);

    // Invalid loads leave CTO and the prescaler alone.
    step(); step();                       // prescaler now 2
    ld = 1'b1; cti = mk(1,5,2,10);
    step();
    check_all("bad_ones", mk(0,0,0,0), 0, 0, 0, 1);
    ld = 1'b0;
    step();
    check_all("bad_ones_after", mk(0,0,0,0), 0, 0, 0, 0);
    step();
    check_all("presc_kept", mk(0,0,0,1), 1, 0, 0, 0);
    ld = 1'b1; cti = mk(0,24,0,0);
    step();
    check_all("bad_hour", mk(0,0,0,1), 0, 0, 0, 1);
    cti = mk(7,0,0,0);
    step();
    check_all("bad_day", mk(0,0,0,1), 0, 0, 0, 1);
    ld = 1'b0;
    for (int i = 1; i <= 3; i++) step();
    check("presc_zero_hold", 32'(min_tick), 32'd0);
    step();
    check_all("after_bad_tick", mk(0,0,0,2), 1, 0, 0, 0);

    // Load coinciding with a prescaler wrap suppresses that tick.
    for (int i = 1; i <= 3; i++) step();  // prescaler now 3
    ld = 1'b1; cti = mk(2,10,3,4);
    step();
    check_all("load_on_wrap", mk(2,10,3,4), 0, 0, 0, 0);
    ld = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("no_tick_post_load", 32'(min_tick), 32'd0);
    end
    step();
    check_all("tick_post_load", mk(2,10,3,5), 1, 0, 0, 0);

    // Load with En low, then Ld held high across more than TICK_DIV cycles.
    en = 1'b0; ld = 1'b1; cti = mk(3,1,5,9);
    step();
    check_all("load_en0", mk(3,1,5,9), 0, 0, 0, 0);
    en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check_all("ld_held", mk(3,1,5,9), 0, 0, 0, 0);
    end
    ld = 1'b0;
    for (int i = 1; i <= 3; i++) step();
    check("ld_held_release", 32'(cto), 32'(mk(3,1,5,9)));
    step();
    check_all("hour_roll", mk(3,2,0,0), 1, 1, 0, 0);

    // En toggling 1,0: minute advances every 8 cycles.
    for (int i = 0; i < 16; i++) begin
      en = (i % 2 == 0);
      step();
      if (i == 5)  check_all("toggle_5",  mk(3,2,0,0), 0, 0, 0, 0);
      if (i == 6)  check_all("toggle_6",  mk(3,2,0,1), 1, 0, 0, 0);
      if (i == 7)  check_all("toggle_7",  mk(3,2,0,1), 0, 0, 0, 0);
      if (i == 14) check_all("toggle_14", mk(3,2,0,2), 1, 0, 0, 0);
    end

    // Clr with a tick pending discards it.
    en = 1'b1;
    for (int i = 1; i <= 3; i++) step();  // prescaler now 3
    clr = 1'b1;
    step();
    check_all("clr_mid", mk(0,0,0,0), 0, 0, 0, 0);
    clr = 1'b0;
    for (int i = 1; i <= 3; i++) step();
    check_all("post_clr_wait", mk(0,0,0,0), 0, 0, 0, 0);
    step();
    check_all("post_clr_tick", mk(0,0,0,1), 1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timekeeper_param.md
TIMEKEEPER_PARAM -- requirements
Module: timekeeper_param

Interface
REQ-001 The block SHALL have a parameter TICK_DIV, default 60, meaning the number of enabled Clk cycles per base time unit (minute, or second when TK_SECONDS_EN is defined).
REQ-002 The block SHALL have a parameter DAY_COUNT, default 7, meaning the number of days in the day cycle (legal range 2..16).
REQ-003 The block SHALL have a parameter DAY_W, default 3, meaning the day field width, which SHALL equal ceil(log2(DAY_COUNT)).
REQ-004 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port Clr, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port En, input, 1 bit: count enable.
REQ-007 The block SHALL have port Ld, input, 1 bit: load request for CTI.
REQ-008 The block SHALL have port CTI, input, 12+DAY_W bits: load value in the CTO field layout.
REQ-009 The block SHALL have port CTO, output, 12+DAY_W bits: current time; [3:0] minute ones (BCD), [6:4] minute tens, [11:7] hour 0-23 (binary), [12+DAY_W-1:12] day.
REQ-010 The block SHALL have port Ld_err, output, 1 bit: one-cycle pulse when a load is rejected.
REQ-011 The block SHALL have ports Min_tick, Hr_tick and Day_tick, each output, 1 bit: one-cycle pulses on minute, hour and day rollover.

Function
REQ-012 The prescaler SHALL increment only when En=1, and SHALL wrap from TICK_DIV-1 to 0, producing a base tick in that cycle.
REQ-013 On a base tick, the minute ones digit SHALL advance 0..9, minute tens 0..5, hour 0..23 and day 0..DAY_COUNT-1, each carrying into the next field at its wrap.
REQ-014 The 23:59 to 00:00 wrap SHALL advance the day, and day DAY_COUNT-1 SHALL wrap to 0.
REQ-015 Min_tick, Hr_tick and Day_tick SHALL be registered, and SHALL be high for exactly the one cycle in which CTO first shows the new minute, hour 0 of the new hour boundary, or the new day, respectively.
REQ-016 Hr_tick SHALL assert on every minute 59 to 00 transition, and Day_tick SHALL assert on every 23:59 to 00:00 transition.
REQ-017 Ld=1 with valid CTI SHALL update CTO on the next edge and SHALL clear the prescaler to 0; a valid CTI has minute ones <= 9, minute tens <= 5, hour <= 23 and day < DAY_COUNT.
REQ-018 Ld=1 with invalid CTI SHALL leave all state unchanged, including the prescaler, and SHALL pulse Ld_err for one cycle.
REQ-019 Priority SHALL be Clr > Ld > count.
REQ-020 A load coinciding with a base tick SHALL suppress that tick, and no tick pulses SHALL occur.
REQ-021 A load SHALL be accepted regardless of En.
REQ-022 When En=0, the prescaler and all time fields SHALL hold their values, and no tick pulses SHALL occur.
REQ-023 Ld held high for N cycles SHALL reload every cycle, keep the prescaler at 0, and produce no counting.

Reset
REQ-024 When Clr=1, the prescaler, CTO (00:00, day 0), Ld_err, Min_tick, Hr_tick and Day_tick SHALL all go to 0 on the next edge; if TK_SECONDS_EN is defined, Sec SHALL also go to 0.
REQ-025 A Clr asserted mid-count SHALL discard any pending tick, and no pulse SHALL be emitted in the reset cycle.
REQ-026 After Clr deasserts, the first base tick SHALL occur TICK_DIV enabled cycles later.

Configuration
REQ-027 When TK_SECONDS_EN is defined, the block SHALL add output port Sec, 7 bits: [3:0] seconds ones (BCD) and [6:4] seconds tens (0..5).
REQ-028 When TK_SECONDS_EN is defined, the base tick SHALL advance Sec, the 59 to 00 wrap of Sec SHALL advance the minute, and Min_tick SHALL follow that wrap.
REQ-029 When TK_SECONDS_EN is defined, a load SHALL clear Sec to 0, and Ld_err validity rules SHALL be unchanged.
REQ-030 When TK_SECONDS_EN is not defined, the Sec port and its logic SHALL not exist, and the base tick SHALL advance minutes directly.

Structure
REQ-031 Package tk_pkg SHALL hold the field width constants (4, 3, 5), the limits (9, 5, 23, 59) and the CTO field offset localparams, shared with the alarm and display blocks.
REQ-032 Sub-module tk_mod_counter SHALL be used for every field: parameters MOD and W; inputs Clk, Clr, Ld, D and Inc; outputs Q and Carry, where Carry = Inc and (Q == MOD-1).

Verification
REQ-033 With TICK_DIV=4, after Clr and then En=1 for 4 cycles, CTO SHALL read minute 01 and Min_tick SHALL pulse once.
REQ-034 Loading 23:59 day 6 and then applying one base tick SHALL give CTO = 00:00 day 0, with Min_tick, Hr_tick and Day_tick all pulsing in the same cycle.
REQ-035 Loading CTI with minute ones = 0xA, or hour = 24, SHALL pulse Ld_err, and CTO and the prescaler SHALL be unchanged.
REQ-036 Asserting Ld in the same cycle as a prescaler wrap SHALL make CTO equal CTI with no tick pulse, and the next tick SHALL follow 4 cycles later.
REQ-037 With En toggling 1,0,1,0,..., the minute SHALL advance every 8 cycles, and Clr asserted mid-sequence SHALL return all outputs to 0 on the next edge.
REQ-038 With TK_SECONDS_EN defined and TICK_DIV=2, 120 cycles SHALL give Sec=00 and minute 01, with Min_tick pulsing once.
